// File: rtl/bcd_addsub_serial.sv
// Digit-serial packed-BCD adder/subtractor: one decimal digit per clock, LS digit first,
// with a start/busy/done handshake and a flag for non-BCD operand digits.
module bcd_addsub_serial #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                op,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                cin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] sum,
  output logic                cout,
  output logic                invalid
);
  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_reg;
  logic [W-1:0]  a_reg, b_reg, acc_reg;
  logic          op_reg, carry_reg, inv_reg;
  logic [CW-1:0] cnt_reg;

  logic [DIGITS-1:0] digit_bad;
  logic [3:0]        bd, digit_next;
  logic [4:0]        raw;
  logic              carry_next;
  logic [W-1:0]      acc_next;

  // Non-BCD detection is done once on the operands as they are captured.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_bad
      assign digit_bad[gi] = (a[4*gi +: 4] > 4'd9) | (b[4*gi +: 4] > 4'd9);
    end
  endgenerate

  // Single-digit decimal slice; subtraction uses the nines complement of b.
  always_comb begin
    bd         = op_reg ? (4'd9 - b_reg[3:0]) : b_reg[3:0];
    raw        = {1'b0, a_reg[3:0]} + {1'b0, bd} + {4'd0, carry_reg};
    digit_next = raw[3:0];
    carry_next = 1'b0;
    if (raw > 5'd9) begin
      digit_next = raw[3:0] + 4'd6;
      carry_next = 1'b1;
    end
  end

  // Result digits enter at the top so digit 0 ends up in [3:0] after DIGITS shifts.
  generate
    if (DIGITS == 1) begin : g_acc1
      assign acc_next = digit_next;
    end else begin : g_accn
      assign acc_next = {digit_next, acc_reg[W-1:4]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      acc_reg   <= '0;
      op_reg    <= 1'b0;
      carry_reg <= 1'b0;
      inv_reg   <= 1'b0;
      cnt_reg   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      invalid   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_reg     <= a;
            b_reg     <= b;
            op_reg    <= op;
            carry_reg <= op ? ~cin : cin;
            inv_reg   <= |digit_bad;
            cnt_reg   <= '0;
            busy      <= 1'b1;
            state_reg <= RUN;
          end
        end
        RUN: begin
          a_reg     <= a_reg >> 4;
          b_reg     <= b_reg >> 4;
          carry_reg <= carry_next;
          acc_reg   <= acc_next;
          cnt_reg   <= cnt_reg + 1'b1;
          if (cnt_reg == LAST) begin
            sum       <= acc_next;
            cout      <= carry_next;
            invalid   <= inv_reg;
            done      <= 1'b1;
            busy      <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_addsub_serial.sv
// Randomized self-checking bench for bcd_addsub_serial against a decimal-arithmetic model,
// with directed cases for carry/borrow boundaries, invalid digits, handshake and reset abort.
module tb_bcd_addsub_serial;
  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         inv;
    int           acc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, cout, invalid;
  logic [W-1:0] sum;

  bcd_addsub_serial #(.DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .invalid(invalid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;
  exp_t q[$];
  logic [W-1:0] hold_sum = '0;
  logic         hold_cout = 1'b0;
  logic         hold_inv = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Reference: plain decimal arithmetic for valid operands, digit-by-digit rule otherwise.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic o, input logic c);
    exp_t   e;
    longint xv = 0, yv = 0, p = 1, t, r;
    int     c_d, raw, xd, yd;
    e.sum = '0; e.cout = 1'b0; e.inv = 1'b0; e.acc = 0;
    for (int k = 0; k < DIGITS; k++)
      if (x[4*k +: 4] > 4'd9 || y[4*k +: 4] > 4'd9) e.inv = 1'b1;
    if (!e.inv) begin
      for (int k = DIGITS - 1; k >= 0; k--) begin
        xv = xv * 10 + longint'(x[4*k +: 4]);
        yv = yv * 10 + longint'(y[4*k +: 4]);
        p  = p * 10;
      end
      if (!o) begin
        t = xv + yv + longint'(c);
        e.cout = (t >= p);
        r = t % p;
      end else begin
        t = xv - yv - longint'(c);
        e.cout = (t >= 0);
        r = (t < 0) ? t + p : t;
      end
      for (int k = 0; k < DIGITS; k++) begin
        e.sum[4*k +: 4] = 4'(r % 10);
        r = r / 10;
      end
    end else begin
      c_d = o ? int'(!c) : int'(c);
      for (int k = 0; k < DIGITS; k++) begin
        xd  = int'(x[4*k +: 4]);
        yd  = int'(y[4*k +: 4]);
        if (o) yd = (9 - yd) & 15;
        raw = xd + yd + c_d;
        if (raw > 9) begin
          e.sum[4*k +: 4] = 4'((raw + 6) & 15);
          c_d = 1;
        end else begin
          e.sum[4*k +: 4] = 4'(raw);
          c_d = 0;
        end
      end
      e.cout = (c_d != 0);
    end
    return e;
  endfunction

  // Compare process: every cycle outside reset.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      chk("busy_done_excl", 64'(busy & done), 64'd0);
      if (done) begin
        if (q.size() == 0) chk("spurious_done", 64'd1, 64'd0);
        else begin
          e = q.pop_front();
          chk("sum", 64'(sum), 64'(e.sum));
          chk("cout", 64'(cout), 64'(e.cout));
          chk("invalid", 64'(invalid), 64'(e.inv));
          chk("latency", 64'(cyc - e.acc), 64'(DIGITS));
          hold_sum = e.sum; hold_cout = e.cout; hold_inv = e.inv;
        end
      end else begin
        chk("hold_sum", 64'(sum), 64'(hold_sum));
        chk("hold_cout", 64'(cout), 64'(hold_cout));
        chk("hold_inv", 64'(invalid), 64'(hold_inv));
      end
      chk("busy", 64'(busy), 64'(q.size() != 0));
    end
  end

  task automatic do_op(input logic [W-1:0] aa, input logic [W-1:0] bb,
                       input logic o, input logic c);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      chk("busy_timeout", 64'd1, 64'd0);
      return;
    end
    a = aa; b = bb; op = o; cin = c; start = 1'b1;
    @(posedge clk);
    #1;
    e = model(aa, bb, o, c);
    e.acc = cyc;
    q.push_back(e);
    $display("op a=%h b=%h op=%0d cin=%0d -> expect sum=%h cout=%0d inv=%0d",
             aa, bb, o, c, e.sum, e.cout, e.inv);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_sum"}, 64'(sum), 64'd0);
    chk({tag, "_cout"}, 64'(cout), 64'd0);
    chk({tag, "_inv"}, 64'(invalid), 64'd0);
  endtask

  task automatic pin(input string name, input logic [W-1:0] aa, input logic [W-1:0] bb,
                     input logic o, input logic c, input logic [W-1:0] s,
                     input logic co, input logic iv);
    exp_t e;
    e = model(aa, bb, o, c);
    chk({name, "_sum"}, 64'(e.sum), 64'(s));
    chk({name, "_cout"}, 64'(e.cout), 64'(co));
    chk({name, "_inv"}, 64'(e.inv), 64'(iv));
  endtask

  function automatic logic [W-1:0] rand_bcd(input bit allow_bad);
    logic [W-1:0] v;
    logic [3:0]   d;
    for (int k = 0; k < DIGITS; k++) begin
      d = 4'($urandom_range(0, 9));
      if (allow_bad && $urandom_range(0, 15) == 0) d = 4'($urandom_range(10, 15));
      v[4*k +: 4] = d;
    end
    return v;
  endfunction

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    pin("pin_add", 16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0);
    pin("pin_wrap", 16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    pin("pin_cin", 16'h9999, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    pin("pin_sub", 16'h5000, 16'h1234, 1'b1, 1'b0, 16'h3766, 1'b1, 1'b0);
    pin("pin_neg", 16'h1234, 16'h5000, 1'b1, 1'b0, 16'h6234, 1'b0, 1'b0);
    pin("pin_bad", 16'h00A0, 16'h0000, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b1);

    #12;
    check_zero_outputs("reset");
    @(negedge clk);
    #1 rst = 1'b0;

    do_op(16'h1234, 16'h5678, 1'b0, 1'b0);
    do_op(16'h9999, 16'h0001, 1'b0, 1'b0);
    do_op(16'h9999, 16'h0000, 1'b0, 1'b1);
    do_op(16'h5000, 16'h1234, 1'b1, 1'b0);
    do_op(16'h1234, 16'h5000, 1'b1, 1'b0);
    do_op(16'h00A0, 16'h0000, 1'b0, 1'b0);
    do_op(16'h0042, 16'h0017, 1'b0, 1'b0);

    // Stray start during RUN, then back-to-back start in the done cycle.
    do_op(16'h4321, 16'h1111, 1'b1, 1'b1);
    @(negedge clk);
    a = 16'h9999; b = 16'h9999; op = 1'b0; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    do_op(16'h0777, 16'h0333, 1'b0, 1'b0);

    // Reset abort two cycles into RUN.
    do_op(16'h2468, 16'h1357, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_zero_outputs("abort");
    q.delete();
    hold_sum = '0; hold_cout = 1'b0; hold_inv = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    do_op(16'h0500, 16'h0499, 1'b0, 1'b1);

    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      do_op(rand_bcd(1'b1), rand_bcd(1'b1), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) chk("drain_timeout", 64'(q.size()), 64'd0);
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/bcd_addsub_serial.md
Name: bcd_addsub_serial

Overview:
- Multi-digit packed-BCD adder/subtractor, DIGITS decimal digits wide.
- Processes one digit per clock, LS digit first, through a single-digit decimal-correct adder slice.
- Start/busy/done handshake.
- Used in datapaths needing wide decimal arithmetic at low area.
- Flags non-BCD operand digits.

Parameters:
DIGITS, 4, number of BCD digits per operand/result (>=1); data width W = 4*DIGITS.

Ports:
clk     input   1   rising-edge clock
rst     input   1   asynchronous active-high reset
start   input   1   request; sampled only when busy=0
op      input   1   0 = add (a+b+cin), 1 = subtract (a-b-cin)
a       input   W   operand A, packed BCD, digit 0 in [3:0]
b       input   W   operand B, packed BCD
cin     input   1   decimal carry-in (add) / borrow-in (sub)
busy    output  1   operation in progress
done    output  1   one-cycle pulse, result valid
sum     output  W   packed BCD result, held until next done
cout    output  1   add: decimal carry-out; sub: 1 = no borrow (a >= b+cin)
invalid output  1   1 = some digit of captured a or b was >9

Behaviour:
- Reset, asynchronous, active-high:
  - busy=0, done=0, sum=0, cout=0, invalid=0, FSM=IDLE.
  - Internal operand registers cleared.
  - Reset asserted mid-operation aborts it; no done is produced.
- FSM states: IDLE, RUN.
- IDLE: start=1 at edge E0:
  - Capture a, b, op, cin.
  - Digit counter = 0; go to RUN; busy=1 after E0.
- Digit-slice arithmetic, applied at edges E1..E_DIGITS (digit k at E(k+1)):
  - bd = b digit when op=0; bd = (9 - b digit) mod 16 when op=1 (nines complement, 4-bit).
  - Initial carry c0 = cin when op=0; c0 = ~cin when op=1.
  - raw = a_k + bd + c (5-bit, max 31).
  - If raw > 9: digit = (raw+6)[3:0], c = 1. Otherwise: digit = raw[3:0], c = 0.
  - Result digits accumulate in an internal shift register; the sum port does not change during RUN.
- Completion at E_DIGITS (latency DIGITS cycles from accept):
  - sum <= accumulated result.
  - cout <= final c.
  - invalid <= OR over all captured a/b digits >9.
  - done=1 for exactly one cycle; busy=0; FSM=IDLE.
- sum, cout and invalid hold their values until the next done or reset.
- start while busy=1: ignored; no effect on the operation in flight.
- start=1 in the cycle done=1: busy is already 0, so start is accepted (back-to-back, no bubble).
- Subtraction result when negative (cout=0): the tens complement of |a-b-cin|.
- Invalid digits are still processed by the rule above, so results are deterministic.
- done and busy are never both 1.

Test Plan (DIGITS=4):
1. add a=0x1234, b=0x5678, cin=0 -> done exactly 4 cycles after accept; sum=0x6912, cout=0, invalid=0; busy high for exactly 4 cycles.
2. add a=0x9999, b=0x0001, cin=0 -> sum=0x0000, cout=1. Repeat with cin=1, b=0x0000 -> sum=0x0000, cout=1.
3. sub a=0x5000, b=0x1234, cin=0 -> sum=0x3766, cout=1. Then sub a=0x1234, b=0x5000 -> sum=0x6234, cout=0.
4. add a=0x00A0, b=0x0000 -> sum=0x0100, cout=0, invalid=1. Next valid operation -> invalid returns to 0.
5. Pulse start again mid-RUN with different operands -> ignored; first result correct. Assert start in the done cycle -> second operation accepted; its done comes 4 cycles later.
6. Assert rst two cycles into RUN -> all outputs 0 immediately (asynchronous); no done pulse; next start yields a correct result.
